// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI-flash responder (mode 0, MSB first) that serves READ (0x03), JEDEC ID
//   (0x9F) and READ STATUS (0x05) from a small preloadable byte memory. All
//   SPI pins are oversampled in the wb_clk_i domain (wb_clk_i >= 4x SCK).
// Ports:
//   wb_clk_i, wb_rst_i       system clock, synchronous active-high reset
//   spi_clk/cs_n/mosi        asynchronous SPI inputs from the master
//   spi_miso, spi_miso_oe    serial data out and its output enable
//   load_we/addr/data        parallel preload port for the byte memory
//   busy                     transaction in progress (synchronized cs_n low)
//   last_cmd                 opcode of the most recent complete command byte
module spi_flash_responder #(
  parameter int          ADDR_W   = 10,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic [7:0]        last_cmd
);

  // Receive shifter only keeps the bits that can matter: the opcode's low 7
  // bits or the low ADDR_W-1 address bits (upper address bits alias away).
  localparam int SH_W = (ADDR_W > 8) ? ADDR_W - 1 : 7;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;

  state_t state, state_d;

  // Synchronizers; sck carries one extra stage for edge detection. Not reset:
  // they only track the pins, and resetting cs_n would fake a "seen high".
  logic [2:0] sck_sync;
  logic [1:0] cs_sync, mosi_sync;
  logic       cs_s, mosi_s, rise, fall;

  always_ff @(posedge wb_clk_i) begin
    sck_sync  <= {sck_sync[1:0], spi_clk};
    cs_sync   <= {cs_sync[0], spi_cs_n};
    mosi_sync <= {mosi_sync[0], spi_mosi};
  end

  assign cs_s   = cs_sync[1];
  assign mosi_s = mosi_sync[1];
  assign rise   = sck_sync[1] & ~sck_sync[2];
  assign fall   = ~sck_sync[1] & sck_sync[2];

  logic [SH_W-1:0]   in_sh;
  logic [4:0]        bit_cnt;
  logic [2:0]        fall_cnt;
  logic [7:0]        tx_sh;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        id_idx;
  logic              load_pend;   // first byte of a response still to be loaded
  logic              armed;       // cs_n has been seen high since reset

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        id_byte, src;

  assign opcode    = {in_sh[6:0], mosi_s};
  assign addr_next = {in_sh[ADDR_W-2:0], mosi_s};

  // Byte memory, synchronous read; mem_q only moves on a fetch so it holds the
  // prefetched byte until the reload point.
  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        mem_q;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  always_ff @(posedge wb_clk_i) begin
    if (load_we) mem[load_addr] <= load_data;
    if (rd_en)   mem_q <= mem[rd_addr];
  end

  always_comb begin
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  end

  always_comb begin
    case (state)
      DATA:    src = mem_q;
      ID:      src = id_byte;
      default: src = 8'h00;
    endcase
  end

  // Fetches: first byte on the final address rise, next byte on the 7th fall
  // so it is ready for the reload on the 8th.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = ptr + ADDR_W'(1);
    if (!cs_s) begin
      if (state == ADDR && rise && bit_cnt == 5'd23) begin
        rd_en   = 1'b1;
        rd_addr = addr_next;
      end else if (state == DATA && !load_pend && fall && fall_cnt == 3'd6) begin
        rd_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (!cs_s && armed) state_d = CMD;
      CMD:
        if (rise && bit_cnt == 5'd7) begin
          case (opcode)
            8'h03:   state_d = ADDR;
            8'h9F:   state_d = ID;
            8'h05:   state_d = STAT;
            default: state_d = IGNORE;
          endcase
        end
      ADDR: if (rise && bit_cnt == 5'd23) state_d = DATA;
      default: ;
    endcase
    // Deselect overrides everything, including a coincident SCK edge.
    if (cs_s) state_d = IDLE;
  end

  assign busy        = (state != IDLE);
  assign spi_miso_oe = (state == DATA) || (state == ID) || (state == STAT);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      spi_miso  <= 1'b0;
      last_cmd  <= 8'h00;
      in_sh     <= '0;
      bit_cnt   <= '0;
      fall_cnt  <= '0;
      tx_sh     <= '0;
      ptr       <= '0;
      id_idx    <= '0;
      load_pend <= 1'b0;
      armed     <= 1'b0;
    end else if (cs_s) begin
      armed     <= 1'b1;
      spi_miso  <= 1'b0;
      bit_cnt   <= '0;
      fall_cnt  <= '0;
      id_idx    <= '0;
      load_pend <= 1'b0;
    end else begin
      case (state)
        CMD:
          if (rise) begin
            in_sh   <= {in_sh[SH_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              last_cmd  <= opcode;
              bit_cnt   <= '0;
              load_pend <= (opcode == 8'h9F) || (opcode == 8'h05);
            end
          end
        ADDR:
          if (rise) begin
            in_sh   <= {in_sh[SH_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              ptr       <= addr_next;
              bit_cnt   <= '0;
              load_pend <= 1'b1;
            end
          end
        DATA, ID, STAT:
          if (load_pend) begin
            // Present bit 7 right away; the first fall re-drives it and only
            // then starts shifting, so each byte spans exactly 8 falls.
            tx_sh     <= src;
            spi_miso  <= src[7];
            id_idx    <= 2'd1;
            fall_cnt  <= '0;
            load_pend <= 1'b0;
          end else if (fall) begin
            spi_miso <= tx_sh[7];
            fall_cnt <= fall_cnt + 3'd1;
            if (fall_cnt == 3'd6 && state == DATA) ptr <= ptr + ADDR_W'(1);
            if (fall_cnt == 3'd7) begin
              tx_sh  <= src;
              id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
            end else begin
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Testbench for spi_flash_responder: drives SPI mode 0 transactions, pushes
// the expected response bytes into a queue, and a monitor collects bytes off
// miso (while miso_oe is set) and compares them against the queue.
module tb_spi_flash_responder;

  localparam int ADDR_W = 10;
  localparam int HP     = 8;   // SCK half period in wb_clk_i cycles

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic              spi_clk  = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso, spi_miso_oe, busy;
  logic              load_we  = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [7:0]        load_data = '0;
  logic [7:0]        last_cmd;

  spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(24'hEF4016)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .last_cmd(last_cmd)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int   n_vec = 0;
  int   n_bad = 0;
  logic [7:0] exp_q[$];
  int   oe_cycles = 0;

  always @(posedge wb_clk_i) if (spi_miso_oe) oe_cycles <= oe_cycles + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: assemble bytes at each SCK rise while the DUT drives miso.
  initial begin
    int         cnt;
    logic [7:0] sh;
    logic [7:0] e;
    cnt = 0;
    sh  = '0;
    forever begin
      @(posedge spi_clk or posedge spi_cs_n);
      if (spi_cs_n) cnt = 0;
      else if (spi_miso_oe) begin
        sh = {sh[6:0], spi_miso};
        cnt++;
        if (cnt == 8) begin
          cnt = 0;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL miso_byte: got %02h expected none", sh);
          end else begin
            e = exp_q.pop_front();
            if (sh !== e) begin
              n_bad++;
              $display("FAIL miso_byte: got %02h expected %02h", sh, e);
            end
          end
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      clks(HP);
      spi_clk = 1'b1;
      clks(HP);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    clks(1);
    spi_cs_n = 1'b0;
    clks(HP);
  endtask

  task automatic cs_high();
    clks(HP);
    spi_cs_n = 1'b1;
    clks(2 * HP);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge wb_clk_i);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge wb_clk_i);
    load_we = 1'b0;
  endtask

  // READ command plus address; caller clocks the data bytes.
  task automatic read_hdr(input logic [23:0] a);
    spi_bits(8'h03, 8);
    spi_bits(a[23:16], 8);
    spi_bits(a[15:8], 8);
    spi_bits(a[7:0], 8);
  endtask

  initial begin
    int snap;
    clks(6);
    check("rst_miso", 32'(spi_miso), 0);
    check("rst_oe", 32'(spi_miso_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_last_cmd", 32'(last_cmd), 32'h00);
    wb_rst_i = 1'b0;
    clks(4);

    load(10'h010, 8'hA5); load(10'h011, 8'h3C);
    load(10'h012, 8'hFF); load(10'h013, 8'h00);
    load(10'h3FF, 8'h11); load(10'h000, 8'h22);

    // Basic 4-byte read, busy release timing
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    cs_low();
    read_hdr(24'h000010);
    repeat (4) spi_bits(8'h00, 8);
    clks(HP);
    spi_cs_n = 1'b1;
    clks(2);
    check("busy_hold", 32'(busy), 1);
    clks(1);
    check("busy_release", 32'(busy), 0);
    clks(2 * HP);
    check("last_cmd_read", 32'(last_cmd), 32'h03);

    // Wrap at top of memory, and upper address bits aliasing
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    cs_low(); read_hdr(24'h0003FF); repeat (2) spi_bits(8'h00, 8); cs_high();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    cs_low(); read_hdr(24'hFC03FF); repeat (2) spi_bits(8'h00, 8); cs_high();

    // JEDEC ID cycles, status reads zero
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
    exp_q.push_back(8'h16); exp_q.push_back(8'hEF);
    cs_low(); spi_bits(8'h9F, 8); repeat (4) spi_bits(8'h00, 8); cs_high();
    check("last_cmd_id", 32'(last_cmd), 32'h9F);
    exp_q.push_back(8'h00);
    cs_low(); spi_bits(8'h05, 8); spi_bits(8'h00, 8); cs_high();
    check("last_cmd_stat", 32'(last_cmd), 32'h05);

    // Unknown opcode: never drives
    snap = oe_cycles;
    cs_low(); spi_bits(8'hAB, 8); spi_bits(8'h55, 8); spi_bits(8'hAA, 8); cs_high();
    check("ignore_oe_cycles", 32'(oe_cycles - snap), 0);
    check("last_cmd_ignore", 32'(last_cmd), 32'hAB);

    // Abort after 4 address bits, then a clean read
    cs_low(); spi_bits(8'h03, 8); spi_bits(8'h00, 4); cs_high();
    exp_q.push_back(8'hA5);
    cs_low(); read_hdr(24'h000010); spi_bits(8'h00, 8); cs_high();
    check("last_cmd_abort", 32'(last_cmd), 32'h03);
    // Partial command byte leaves last_cmd alone
    cs_low(); spi_bits(8'h9F, 4); cs_high();
    check("last_cmd_partial", 32'(last_cmd), 32'h03);

    // Reset in the middle of DATA with cs_n held low
    exp_q.push_back(8'hA5);
    cs_low(); read_hdr(24'h000010); spi_bits(8'h00, 8); spi_bits(8'h00, 3);
    wb_rst_i = 1'b1;
    clks(4);
    check("midrst_oe", 32'(spi_miso_oe), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_last_cmd", 32'(last_cmd), 32'h00);
    wb_rst_i = 1'b0;
    snap = oe_cycles;
    spi_bits(8'h00, 5); spi_bits(8'h03, 8); spi_bits(8'h00, 8);
    check("postrst_oe_cycles", 32'(oe_cycles - snap), 0);
    check("postrst_busy", 32'(busy), 0);
    cs_high();
    exp_q.push_back(8'h3C);
    cs_low(); read_hdr(24'h000011); spi_bits(8'h00, 8); cs_high();
    check("last_cmd_after_rst", 32'(last_cmd), 32'h03);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
